// File: rtl/bn_wb_packer.sv
// bn_wb_packer: write-back packer for the radix-16 datapath.
// Packs the 16 butterfly results into eight memory words, delays the read-time
// control by the butterfly latency, and issues one registered write per group
// to bank BN0 or BN1. A group counter pulses done on the last write of a stage.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   clear                     synchronous stage clear (flush in-flight groups, zero counter)
//   ctrl_valid/BN_sel_in/MA_in  group issue: valid, destination bank, write-back address
//   RA0_in..RA15_in           butterfly results, valid DELAY cycles after ctrl_valid
//   MEM0_wdata..MEM7_wdata    packed write data shared by both banks
//   BN0_wen, BN1_wen          bank write enables (mutually exclusive)
//   waddr                     write address shared by both banks
//   done                      pulse with the GROUPS-th write of a stage
module bn_wb_packer #(
  parameter int unsigned SD_WIDTH   = 128,
  parameter int unsigned P_WIDTH    = 64,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DELAY      = 4,
  parameter int unsigned GROUPS     = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  ctrl_valid,
  input  logic                  BN_sel_in,
  input  logic [ADDR_WIDTH-1:0] MA_in,
  input  logic [P_WIDTH-1:0]    RA0_in,
  input  logic [P_WIDTH-1:0]    RA1_in,
  input  logic [P_WIDTH-1:0]    RA2_in,
  input  logic [P_WIDTH-1:0]    RA3_in,
  input  logic [P_WIDTH-1:0]    RA4_in,
  input  logic [P_WIDTH-1:0]    RA5_in,
  input  logic [P_WIDTH-1:0]    RA6_in,
  input  logic [P_WIDTH-1:0]    RA7_in,
  input  logic [P_WIDTH-1:0]    RA8_in,
  input  logic [P_WIDTH-1:0]    RA9_in,
  input  logic [P_WIDTH-1:0]    RA10_in,
  input  logic [P_WIDTH-1:0]    RA11_in,
  input  logic [P_WIDTH-1:0]    RA12_in,
  input  logic [P_WIDTH-1:0]    RA13_in,
  input  logic [P_WIDTH-1:0]    RA14_in,
  input  logic [P_WIDTH-1:0]    RA15_in,
  output logic [SD_WIDTH-1:0]   MEM0_wdata,
  output logic [SD_WIDTH-1:0]   MEM1_wdata,
  output logic [SD_WIDTH-1:0]   MEM2_wdata,
  output logic [SD_WIDTH-1:0]   MEM3_wdata,
  output logic [SD_WIDTH-1:0]   MEM4_wdata,
  output logic [SD_WIDTH-1:0]   MEM5_wdata,
  output logic [SD_WIDTH-1:0]   MEM6_wdata,
  output logic [SD_WIDTH-1:0]   MEM7_wdata,
  output logic                  BN0_wen,
  output logic                  BN1_wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic                  done
);

  localparam int unsigned NPTS   = 16;
  localparam int unsigned NWORDS = 8;
  localparam int unsigned CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  logic [P_WIDTH-1:0]    w_ra [NPTS];
  logic [DELAY-1:0]      r_dv;
  logic [DELAY-1:0]      r_ds;
  logic [ADDR_WIDTH-1:0] r_da [DELAY];
  logic                  w_tail_valid;
  logic                  w_tail_sel;
  logic [ADDR_WIDTH-1:0] w_tail_addr;
  logic                  w_wr;
  logic                  w_last;
  logic [CNT_W-1:0]      r_cnt;
  logic [SD_WIDTH-1:0]   r_wdata [NWORDS];
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic                  r_wen0;
  logic                  r_wen1;
  logic                  r_done;

  assign w_ra[0]  = RA0_in;
  assign w_ra[1]  = RA1_in;
  assign w_ra[2]  = RA2_in;
  assign w_ra[3]  = RA3_in;
  assign w_ra[4]  = RA4_in;
  assign w_ra[5]  = RA5_in;
  assign w_ra[6]  = RA6_in;
  assign w_ra[7]  = RA7_in;
  assign w_ra[8]  = RA8_in;
  assign w_ra[9]  = RA9_in;
  assign w_ra[10] = RA10_in;
  assign w_ra[11] = RA11_in;
  assign w_ra[12] = RA12_in;
  assign w_ra[13] = RA13_in;
  assign w_ra[14] = RA14_in;
  assign w_ra[15] = RA15_in;

  // Valid chain of the control delay line; the only part that resets/clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dv <= '0;
    end else if (clear) begin
      r_dv <= '0;
    end else begin
      r_dv[0] <= ctrl_valid;
      for (int i = 1; i < int'(DELAY); i++) r_dv[i] <= r_dv[i-1];
    end
  end

  // Bank select and address ride alongside valid; meaningless while valid is 0.
  always_ff @(posedge clk) begin
    r_ds[0] <= BN_sel_in;
    r_da[0] <= MA_in;
    for (int i = 1; i < int'(DELAY); i++) begin
      r_ds[i] <= r_ds[i-1];
      r_da[i] <= r_da[i-1];
    end
  end

  assign w_tail_valid = r_dv[DELAY-1];
  assign w_tail_sel   = r_ds[DELAY-1];
  assign w_tail_addr  = r_da[DELAY-1];
  // clear drops the group arriving at the tail in the same cycle.
  assign w_wr         = w_tail_valid & ~clear;
  assign w_last       = (r_cnt == CNT_W'(GROUPS - 1));

  // Write stage: enables, done and group counter; data/address load only on a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wen0  <= 1'b0;
      r_wen1  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_waddr <= '0;
      r_wdata <= '{default: '0};
    end else begin
      r_wen0 <= w_wr & ~w_tail_sel;
      r_wen1 <= w_wr & w_tail_sel;
      r_done <= w_wr & w_last;
      if (clear) begin
        r_cnt <= '0;
      end else if (w_wr) begin
        r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
      end
      if (w_wr) begin
        r_waddr <= w_tail_addr;
        // Even point in the upper half: inverse of the read-side slicing.
        for (int k = 0; k < int'(NWORDS); k++) r_wdata[k] <= {w_ra[2*k], w_ra[2*k+1]};
      end
    end
  end

  assign MEM0_wdata = r_wdata[0];
  assign MEM1_wdata = r_wdata[1];
  assign MEM2_wdata = r_wdata[2];
  assign MEM3_wdata = r_wdata[3];
  assign MEM4_wdata = r_wdata[4];
  assign MEM5_wdata = r_wdata[5];
  assign MEM6_wdata = r_wdata[6];
  assign MEM7_wdata = r_wdata[7];
  assign BN0_wen    = r_wen0;
  assign BN1_wen    = r_wen1;
  assign waddr      = r_waddr;
  assign done       = r_done;

endmodule

// File: tb/tb_bn_wb_packer.sv
// Bench for bn_wb_packer: three instances (DELAY 4, 1, 16) share one stimulus
// stream; a cycle-level model predicts every output of each instance.
module tb_bn_wb_packer;

  localparam int ND = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        ctrl_valid;
  logic        sel;
  logic [5:0]  ma;
  logic [63:0] ra [16];

  logic [1023:0] mon_data [ND];
  logic [8:0]    mon_ctl  [ND];   // {BN0_wen, BN1_wen, done, waddr}

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    logic [127:0] wd [8];
    logic         w0, w1, dn;
    logic [5:0]   wa;
    bn_wb_packer #(
      .SD_WIDTH(128), .P_WIDTH(64), .ADDR_WIDTH(6),
      .DELAY((g == 0) ? 4 : ((g == 1) ? 1 : 16)), .GROUPS(64)
    ) u_dut (
      .clk(clk), .rst(rst), .clear(clear), .ctrl_valid(ctrl_valid),
      .BN_sel_in(sel), .MA_in(ma),
      .RA0_in(ra[0]),   .RA1_in(ra[1]),   .RA2_in(ra[2]),   .RA3_in(ra[3]),
      .RA4_in(ra[4]),   .RA5_in(ra[5]),   .RA6_in(ra[6]),   .RA7_in(ra[7]),
      .RA8_in(ra[8]),   .RA9_in(ra[9]),   .RA10_in(ra[10]), .RA11_in(ra[11]),
      .RA12_in(ra[12]), .RA13_in(ra[13]), .RA14_in(ra[14]), .RA15_in(ra[15]),
      .MEM0_wdata(wd[0]), .MEM1_wdata(wd[1]), .MEM2_wdata(wd[2]), .MEM3_wdata(wd[3]),
      .MEM4_wdata(wd[4]), .MEM5_wdata(wd[5]), .MEM6_wdata(wd[6]), .MEM7_wdata(wd[7]),
      .BN0_wen(w0), .BN1_wen(w1), .waddr(wa), .done(dn)
    );
    assign mon_data[g] = {wd[0], wd[1], wd[2], wd[3], wd[4], wd[5], wd[6], wd[7]};
    assign mon_ctl[g]  = {w0, w1, dn, wa};
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic int dly(input int g);
    return (g == 0) ? 4 : ((g == 1) ? 1 : 16);
  endfunction

  // Model: a group issued at edge c is written at edge c+D unless a clear or
  // reset occurs at any edge in between (inclusive); writes are numbered per stage.
  logic       hv [32];
  logic       hs [32];
  logic [5:0] ha [32];
  logic [8:0]   e_ctl  [ND];
  logic [127:0] e_data [ND][8];
  int           e_cnt  [ND];
  int           cyc = 0;

  initial begin
    for (int i = 0; i < 32; i++) begin hv[i] = 1'b0; hs[i] = 1'b0; ha[i] = '0; end
    for (int g = 0; g < ND; g++) begin
      e_ctl[g] = '0; e_cnt[g] = 0;
      for (int k = 0; k < 8; k++) e_data[g][k] = '0;
    end
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int g = 0; g < ND; g++) begin
          e_ctl[g] = '0; e_cnt[g] = 0;
          for (int k = 0; k < 8; k++) e_data[g][k] = '0;
        end
      end
      // Compare outputs produced by the previous rising edge.
      for (int g = 0; g < ND; g++) begin
        check($sformatf("d%0d_ctl", g), 128'(mon_ctl[g]), 128'(e_ctl[g]));
        for (int k = 0; k < 8; k++)
          check($sformatf("d%0d_mem%0d", g, k), mon_data[g][1023-128*k -: 128], e_data[g][k]);
      end
      // Predict the outputs of the coming rising edge.
      if (rst) begin
        for (int i = 0; i < 32; i++) hv[i] = 1'b0;
      end else begin
        for (int g = 0; g < ND; g++) begin
          int idx;
          idx = (cyc - dly(g)) & 31;
          e_ctl[g][8:6] = 3'b000;
          if (clear) begin
            e_cnt[g] = 0;
          end else if (hv[idx]) begin
            e_ctl[g] = {~hs[idx], hs[idx], (e_cnt[g] == 63), ha[idx]};
            for (int k = 0; k < 8; k++) e_data[g][k] = {ra[2*k], ra[2*k+1]};
            e_cnt[g] = (e_cnt[g] + 1) % 64;
          end
        end
        if (clear) for (int i = 0; i < 32; i++) hv[i] = 1'b0;
      end
      hv[cyc & 31] = ctrl_valid & ~clear & ~rst;
      hs[cyc & 31] = sel;
      ha[cyc & 31] = ma;
      cyc++;
    end
  end

  // Write/done bookkeeping for the DELAY=4 instance (used by directed checks).
  int wr_total = 0;
  int done_q [$];
  always @(negedge clk) begin
    if (mon_ctl[0][8] | mon_ctl[0][7]) begin
      wr_total = wr_total + 1;
      if (mon_ctl[0][6]) done_q.push_back(wr_total);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) ra[i] = {$urandom, $urandom};
  endtask

  task automatic issue(input logic s, input logic [5:0] a);
    ctrl_valid = 1'b1; sel = s; ma = a;
  endtask

  int first [ND];
  int wr_base;
  int dn_base;

  initial begin
    rst = 1'b1; clear = 1'b0; ctrl_valid = 1'b0; sel = 1'b0; ma = '0;
    for (int i = 0; i < 16; i++) ra[i] = '0;
    repeat (3) tick();
    check("rst_ctl", 128'(mon_ctl[0]), 128'd0);
    check("rst_mem0", mon_data[0][1023:896], 128'd0);
    rst = 1'b0;
    repeat (5) tick();

    // Single group to BN0, addr 5, RAi = i+1; latency sweep over all three delays.
    for (int g = 0; g < ND; g++) first[g] = 0;
    issue(1'b0, 6'd5);
    for (int k = 1; k <= 20; k++) begin
      tick();
      ctrl_valid = 1'b0;
      for (int g = 0; g < ND; g++)
        if (first[g] == 0 && (mon_ctl[g][8] | mon_ctl[g][7])) first[g] = k;
      if (k == 4) for (int i = 0; i < 16; i++) ra[i] = 64'(i + 1);
      if (k == 5) begin
        check("single_ctl", 128'(mon_ctl[0]), 128'({1'b1, 1'b0, 1'b0, 6'd5}));
        check("single_mem0", mon_data[0][1023:896], {64'd1, 64'd2});
        check("single_mem7", mon_data[0][127:0], {64'd15, 64'd16});
      end
    end
    check("lat_d4", 128'(first[0]), 128'd5);
    check("lat_d1", 128'(first[1]), 128'd2);
    check("lat_d16", 128'(first[2]), 128'd17);

    clear = 1'b1; tick(); clear = 1'b0; tick();

    // Streaming: 128 back-to-back groups, alternating banks, addr 0..63 twice.
    wr_base = wr_total; done_q.delete();
    for (int i = 0; i < 128; i++) begin
      issue(i[0], 6'(i));
      tick();
    end
    ctrl_valid = 1'b0;
    repeat (20) tick();
    check("stream_writes", 128'(wr_total - wr_base), 128'd128);
    check("stream_done_n", 128'(done_q.size()), 128'd2);
    check("stream_done_a", 128'(done_q[0] - wr_base), 128'd64);
    check("stream_done_b", 128'(done_q[1] - wr_base), 128'd128);

    // Bubbles: 0..3 idle cycles between 10 groups.
    wr_base = wr_total;
    for (int i = 0; i < 10; i++) begin
      issue(i[0], 6'(40 + i));
      tick();
      ctrl_valid = 1'b0;
      repeat (i % 4) tick();
    end
    repeat (20) tick();
    check("bubble_writes", 128'(wr_total - wr_base), 128'd10);

    // Bring the stage counter to 63 so the next write would raise done.
    for (int i = 0; i < 53; i++) begin
      issue(1'b1, 6'(i));
      tick();
    end
    ctrl_valid = 1'b0;
    repeat (20) tick();

    // Clear collision: clear meets the tail of the first of three groups.
    wr_base = wr_total; dn_base = done_q.size();
    issue(1'b0, 6'd1); tick();
    issue(1'b1, 6'd2); tick();
    issue(1'b0, 6'd3); tick();
    ctrl_valid = 1'b0; tick();
    clear = 1'b1; tick();
    clear = 1'b0;
    repeat (20) tick();
    check("clr_writes", 128'(wr_total - wr_base), 128'd0);
    check("clr_done", 128'(done_q.size() - dn_base), 128'd0);
    issue(1'b1, 6'd7); tick();
    ctrl_valid = 1'b0;
    repeat (20) tick();
    check("clr_after_writes", 128'(wr_total - wr_base), 128'd1);
    check("clr_after_done", 128'(done_q.size() - dn_base), 128'd0);

    // Reset mid-stage with three groups in flight.
    issue(1'b0, 6'd10); tick();
    issue(1'b1, 6'd11); tick();
    issue(1'b0, 6'd12); tick();
    ctrl_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rstmid_ctl", 128'(mon_ctl[0]), 128'd0);
    check("rstmid_mem0", mon_data[0][1023:896], 128'd0);
    check("rstmid_mem7", mon_data[0][127:0], 128'd0);
    repeat (2) tick();
    rst = 1'b0;
    wr_base = wr_total; dn_base = done_q.size();
    repeat (20) tick();
    check("rstmid_nowen", 128'(wr_total - wr_base), 128'd0);
    for (int i = 0; i < 64; i++) begin
      issue(i[0], 6'(63 - i));
      tick();
    end
    ctrl_valid = 1'b0;
    repeat (20) tick();
    check("rstmid_writes", 128'(wr_total - wr_base), 128'd64);
    check("rstmid_done_n", 128'(done_q.size() - dn_base), 128'd1);
    check("rstmid_done_at", 128'(done_q[dn_base] - wr_base), 128'd64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
